// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan driver: segment patterns, converter
// state codes and the digit index width.
package seg7_pkg;

  localparam int DIG_W = 2;

  localparam logic [1:0] CNV_IDLE  = 2'd0;
  localparam logic [1:0] CNV_SHIFT = 2'd1;
  localparam logic [1:0] CNV_DONE  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = CNV_IDLE,
    ST_SHIFT = CNV_SHIFT,
    ST_DONE  = CNV_DONE
  } cnv_state_e;

  // Active-high patterns, bit0 = a ... bit6 = g
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    logic [6:0] pat;
    case (digit)
      4'd0:    pat = SEG_0;
      4'd1:    pat = SEG_1;
      4'd2:    pat = SEG_2;
      4'd3:    pat = SEG_3;
      4'd4:    pat = SEG_4;
      4'd5:    pat = SEG_5;
      4'd6:    pat = SEG_6;
      4'd7:    pat = SEG_7;
      4'd8:    pat = SEG_8;
      4'd9:    pat = SEG_9;
      default: pat = SEG_BLANK;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: converts an 8-bit value into three BCD digits over
// eight shift cycles, publishing only complete results.
module bin2bcd_seq
  import seg7_pkg::*;
(
  input  logic        clc_i,
  input  logic        rst_i,
  input  logic [7:0]  bin_i,
  output logic [11:0] bcd_o,
  output logic        busy_o
);

  cnv_state_e  state_r;
  logic [7:0]  last_r;
  logic [7:0]  shreg_r;
  logic [11:0] scratch_r;
  logic [2:0]  iter_r;
  logic [11:0] adj_s;

  // Add-3 correction of every scratch nibble that is 5 or more
  always_comb begin
    adj_s = scratch_r;
    for (int i = 0; i < 3; i++) begin
      if (scratch_r[i*4 +: 4] >= 4'd5) begin
        adj_s[i*4 +: 4] = scratch_r[i*4 +: 4] + 4'd3;
      end else begin
        adj_s[i*4 +: 4] = scratch_r[i*4 +: 4];
      end
    end
  end

  // Converter FSM; input changes are only looked at in IDLE
  always_ff @(posedge clc_i) begin
    if (rst_i) begin
      state_r   <= ST_IDLE;
      last_r    <= 8'd0;
      shreg_r   <= 8'd0;
      scratch_r <= 12'd0;
      iter_r    <= 3'd0;
      bcd_o     <= 12'd0;
      busy_o    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bin_i != last_r) begin
            shreg_r   <= bin_i;
            last_r    <= bin_i;
            scratch_r <= 12'd0;
            iter_r    <= 3'd0;
            state_r   <= ST_SHIFT;
            busy_o    <= 1'b1;
          end else begin
            busy_o    <= 1'b0;
          end
        end
        ST_SHIFT: begin
          {scratch_r, shreg_r} <= {adj_s[10:0], shreg_r, 1'b0};
          iter_r <= iter_r + 3'd1;
          if (iter_r == 3'd7) begin
            state_r <= ST_DONE;
          end else begin
            state_r <= ST_SHIFT;
          end
        end
        ST_DONE: begin
          bcd_o   <= scratch_r;
          state_r <= ST_IDLE;
          busy_o  <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed 7-segment driver: three BCD digits of the indication
// value with leading-zero blanking, plus the FSM state code with decimal point.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV   = 1024,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic        clc_i,
  input  logic        rst_i,
  input  logic [7:0]  dind_i,
  input  logic [1:0]  state_i,
  output logic [6:0]  seg_o,
  output logic        dp_o,
  output logic [3:0]  an_o,
  output logic [11:0] bcd_o,
  output logic        busy_o
);

  localparam int              CNT_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);
  localparam logic [6:0]      SEG_OFF = ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [3:0]      AN_OFF  = ACTIVE_LOW ? 4'hF : 4'h0;
  localparam logic            DP_OFF  = ACTIVE_LOW ? 1'b1 : 1'b0;

  logic [CNT_W-1:0] cnt_r;
  logic [DIG_W-1:0] digit_idx_r;
  logic [3:0]       hund_s;
  logic [3:0]       tens_s;
  logic [3:0]       ones_s;
  logic [6:0]       seg_s;
  logic [3:0]       an_s;
  logic             dp_s;

  bin2bcd_seq u_bcd (
    .clc_i  (clc_i),
    .rst_i  (rst_i),
    .bin_i  (dind_i),
    .bcd_o  (bcd_o),
    .busy_o (busy_o)
  );

  // Prescaler and digit index
  always_ff @(posedge clc_i) begin
    if (rst_i) begin
      cnt_r       <= '0;
      digit_idx_r <= '0;
    end else if (cnt_r == CNT_MAX) begin
      cnt_r       <= '0;
      digit_idx_r <= digit_idx_r + DIG_W'(1);
    end else begin
      cnt_r       <= cnt_r + CNT_W'(1);
    end
  end

  assign hund_s = bcd_o[11:8];
  assign tens_s = bcd_o[7:4];
  assign ones_s = bcd_o[3:0];

  // Active-high content of the current digit, blanking leading zeros
  always_comb begin
    seg_s = SEG_BLANK;
    an_s  = 4'b0000;
    dp_s  = 1'b0;
    case (digit_idx_r)
      2'd0: begin
        seg_s = seg_decode(ones_s);
        an_s  = 4'b0001;
      end
      2'd1: begin
        if ((hund_s == 4'd0) && (tens_s == 4'd0)) begin
          seg_s = SEG_BLANK;
          an_s  = 4'b0000;
        end else begin
          seg_s = seg_decode(tens_s);
          an_s  = 4'b0010;
        end
      end
      2'd2: begin
        if (hund_s == 4'd0) begin
          seg_s = SEG_BLANK;
          an_s  = 4'b0000;
        end else begin
          seg_s = seg_decode(hund_s);
          an_s  = 4'b0100;
        end
      end
      2'd3: begin
        seg_s = seg_decode({2'b00, state_i});
        an_s  = 4'b1000;
        dp_s  = 1'b1;
      end
      default: begin
        seg_s = SEG_BLANK;
        an_s  = 4'b0000;
        dp_s  = 1'b0;
      end
    endcase
  end

  // Pin registers with board polarity applied
  always_ff @(posedge clc_i) begin
    if (rst_i) begin
      seg_o <= SEG_OFF;
      an_o  <= AN_OFF;
      dp_o  <= DP_OFF;
    end else begin
      seg_o <= seg_s ^ {7{ACTIVE_LOW}};
      an_o  <= an_s ^ {4{ACTIVE_LOW}};
      dp_o  <= dp_s ^ ACTIVE_LOW;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver: a decimal/timeline model checked
// every cycle, plus directed literal expectations.
module tb_seg7_scan_driver;

  localparam int SCAN_DIV   = 4;
  localparam bit ACTIVE_LOW = 1'b1;

  logic        clc;
  logic        rst;
  logic [7:0]  dind;
  logic [1:0]  state;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic [11:0] bcd;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  seg7_scan_driver #(.SCAN_DIV(SCAN_DIV), .ACTIVE_LOW(ACTIVE_LOW)) dut (
    .clc_i   (clc),
    .rst_i   (rst),
    .dind_i  (dind),
    .state_i (state),
    .seg_o   (seg),
    .dp_o    (dp),
    .an_o    (an),
    .bcd_o   (bcd),
    .busy_o  (busy)
  );

  initial clc = 1'b0;
  always #5 clc = ~clc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] hex7(input int d);
    logic [6:0] p;
    case (d)
      0: p = 7'h3F; 1: p = 7'h06; 2: p = 7'h5B; 3: p = 7'h4F; 4: p = 7'h66;
      5: p = 7'h6D; 6: p = 7'h7D; 7: p = 7'h07; 8: p = 7'h7F; 9: p = 7'h6F;
      default: p = 7'h00;
    endcase
    return p;
  endfunction

  function automatic logic [11:0] to_bcd(input int v);
    return 12'(((v / 100) << 8) | (((v / 10) % 10) << 4) | (v % 10));
  endfunction

  // Reference model: cycles since reset give the digit; a conversion takes 9 edges
  int         m_cyc, m_cnt, m_last, m_val;
  int         m_idx, m_h, m_t, m_o;
  logic [6:0] m_p, m_seg;
  logic [3:0] m_a, m_an;
  logic       m_d, m_dp;
  bit         m_valid = 1'b0;

  initial begin
    forever begin
      @(posedge clc);
      if (rst) begin
        m_cyc = 0; m_cnt = 0; m_last = 0; m_val = 0;
        m_seg = 7'h7F; m_an = 4'hF; m_dp = 1'b1;
        m_valid = 1'b1;
      end else begin
        m_idx = (m_cyc / SCAN_DIV) % 4;
        m_h = m_val / 100; m_t = (m_val / 10) % 10; m_o = m_val % 10;
        m_p = 7'h00; m_a = 4'h0; m_d = 1'b0;
        if (m_idx == 0) begin
          m_p = hex7(m_o); m_a = 4'h1;
        end else if (m_idx == 1) begin
          if (m_h != 0 || m_t != 0) begin m_p = hex7(m_t); m_a = 4'h2; end
        end else if (m_idx == 2) begin
          if (m_h != 0) begin m_p = hex7(m_h); m_a = 4'h4; end
        end else begin
          m_p = hex7(int'(state)); m_a = 4'h8; m_d = 1'b1;
        end
        m_seg = ACTIVE_LOW ? ~m_p : m_p;
        m_an  = ACTIVE_LOW ? ~m_a : m_a;
        m_dp  = ACTIVE_LOW ? ~m_d : m_d;
        m_cyc++;
        if (m_cnt == 0) begin
          if (int'(dind) != m_last) begin m_last = int'(dind); m_cnt = 9; end
        end else begin
          m_cnt--;
          if (m_cnt == 0) m_val = m_last;
        end
      end
    end
  end

  // Per-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clc);
      if (m_valid) begin
        check("model_seg", {25'd0, seg}, {25'd0, m_seg});
        check("model_an", {28'd0, an}, {28'd0, m_an});
        check("model_dp", {31'd0, dp}, {31'd0, m_dp});
        check("model_bcd", {20'd0, bcd}, {20'd0, to_bcd(m_val)});
        check("model_busy", {31'd0, busy}, {31'd0, (m_cnt > 0)});
      end
    end
  end

  logic [6:0] cap_seg [4];
  logic       cap_dp  [4];
  bit         cap_seen [4];
  int         blank_cnt, blank_bad, dp_bad, hot_bad;

  task automatic scan(input int ncyc);
    for (int i = 0; i < 4; i++) begin cap_seg[i] = 7'h00; cap_dp[i] = 1'b0; cap_seen[i] = 1'b0; end
    blank_cnt = 0; blank_bad = 0; dp_bad = 0; hot_bad = 0;
    repeat (ncyc) begin
      @(negedge clc);
      case (an)
        4'hE: begin cap_seg[0] = seg; cap_dp[0] = dp; cap_seen[0] = 1'b1; end
        4'hD: begin cap_seg[1] = seg; cap_dp[1] = dp; cap_seen[1] = 1'b1; end
        4'hB: begin cap_seg[2] = seg; cap_dp[2] = dp; cap_seen[2] = 1'b1; end
        4'h7: begin cap_seg[3] = seg; cap_dp[3] = dp; cap_seen[3] = 1'b1; end
        4'hF: begin blank_cnt++; if (seg !== 7'h7F) blank_bad++; end
        default: hot_bad++;
      endcase
      if (an !== 4'h7 && dp !== 1'b1) dp_bad++;
    end
  endtask

  int         bcnt;
  int         nchg;
  logic [11:0] prev;
  logic [11:0] chg_val [4];
  int         chg_cyc [4];
  bit         found;

  initial begin
    rst = 1'b1; dind = 8'd0; state = 2'd0;
    repeat (2) @(negedge clc);
    check("rst_an", {28'd0, an}, 32'hF);
    check("rst_seg", {25'd0, seg}, 32'h7F);
    check("rst_dp", {31'd0, dp}, 32'h1);
    check("rst_bcd", {20'd0, bcd}, 32'h000);
    check("rst_busy", {31'd0, busy}, 32'h0);
    rst = 1'b0;
    @(negedge clc);
    check("rel_an", {28'd0, an}, 32'hE);
    check("rel_seg", {25'd0, seg}, 32'h40);

    // Full-scale value
    dind = 8'd255; state = 2'd1; bcnt = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clc);
      if (busy) bcnt++;
      else if (bcnt > 0) break;
    end
    check("busy_len", bcnt, 9);
    check("bcd_255", {20'd0, bcd}, 32'h255);
    scan(4 * SCAN_DIV);
    check("fs_d0", {25'd0, cap_seg[0]}, 32'h12);
    check("fs_d1", {25'd0, cap_seg[1]}, 32'h12);
    check("fs_d2", {25'd0, cap_seg[2]}, 32'h24);
    check("fs_d3", {25'd0, cap_seg[3]}, 32'h79);
    check("fs_blank", blank_cnt, 0);
    check("fs_hot", hot_bad, 0);

    // Leading-zero blanking
    dind = 8'd7;
    repeat (14) @(negedge clc);
    scan(4 * SCAN_DIV);
    check("b7_d0", {25'd0, cap_seg[0]}, 32'h78);
    check("b7_blank", blank_cnt, 2 * SCAN_DIV);
    check("b7_blankseg", blank_bad, 0);
    dind = 8'd40;
    repeat (14) @(negedge clc);
    scan(4 * SCAN_DIV);
    check("b40_d0", {25'd0, cap_seg[0]}, 32'h40);
    check("b40_d1", {25'd0, cap_seg[1]}, 32'h19);
    check("b40_blank", blank_cnt, SCAN_DIV);

    // Change during conversion
    dind = 8'd100; prev = bcd; nchg = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clc);
      if (c == 3) dind = 8'd42;
      if (bcd !== prev) begin
        if (nchg < 4) begin chg_val[nchg] = bcd; chg_cyc[nchg] = c; end
        nchg++;
        prev = bcd;
      end
    end
    check("chg_count", nchg, 2);
    if (nchg >= 2) begin
      check("chg_first", {20'd0, chg_val[0]}, 32'h100);
      check("chg_second", {20'd0, chg_val[1]}, 32'h042);
      check("chg_gap", chg_cyc[1] - chg_cyc[0], 10);
    end

    // State digit
    state = 2'd2;
    scan(4 * SCAN_DIV);
    check("st_seen", {31'd0, cap_seen[3]}, 32'h1);
    check("st_seg", {25'd0, cap_seg[3]}, 32'h24);
    check("st_dp", {31'd0, cap_dp[3]}, 32'h0);
    check("st_dpoff", dp_bad, 0);

    // Reset mid-conversion at iter=4
    dind = 8'd200;
    @(negedge clc);
    repeat (4) @(negedge clc);
    check("mid_busy_pre", {31'd0, busy}, 32'h1);
    rst = 1'b1;
    @(negedge clc);
    check("mid_busy", {31'd0, busy}, 32'h0);
    check("mid_bcd", {20'd0, bcd}, 32'h000);
    rst = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clc);
      if (bcd === 12'h200) begin found = 1'b1; break; end
    end
    check("mid_reconv", {31'd0, found}, 32'h1);

    // Randomised traffic under the model
    repeat (600) begin
      @(negedge clc);
      if ($urandom_range(0, 7) == 0) dind = 8'($urandom);
      state = 2'($urandom);
      rst = ($urandom_range(0, 79) == 0);
    end
    rst = 1'b0;
    repeat (3) @(negedge clc);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Display-side consumer of the counter FSM's indication bus. It takes the 8-bit indication value and the 2-bit FSM state code, and converts the value to three BCD digits with a sequential double-dabble. It then drives a 4-digit multiplexed common-anode 7-segment display: digits 0..2 show the value, digit 3 shows the state code. It sits between the counter FSM outputs and the board display pins.

## Interface
- SCAN_DIV, 1024: clock cycles each digit stays lit; must be ≥1.
- ACTIVE_LOW, 1: when 1, `seg_o`, `dp_o` and `an_o` are active-low; when 0, they are active-high.
- clc_i  in  1  display clock, the block's only clock.
- rst_i  in  1  reset, synchronous, active-high.
- dind_i  in  8  binary value to display, 0..255.
- state_i  in  2  FSM state code, 0..3.
- seg_o  out  7  segment drive; bit0=a … bit6=g.
- dp_o  out  1  decimal point drive.
- an_o  out  4  digit enable, one-hot; bit n = digit n.
- bcd_o  out  12  converted value {hundreds, tens, ones} (debug/verification).
- busy_o  out  1  conversion in progress.

## Operation
- **Converter FSM states:** IDLE, SHIFT, DONE.
  - IDLE: if `dind_i` ≠ `last_q`, capture `dind_i` into the shift register and into `last_q`, clear the BCD scratch, set iter=0, and go to SHIFT.
  - SHIFT: each cycle, add 3 to every scratch nibble ≥5, then shift {scratch, shreg} left by 1 and increment iter. After the 8th shift, go to DONE.
  - DONE: load `bcd_o` from the scratch, then go to IDLE.
- Changes on `dind_i` during SHIFT or DONE are ignored. IDLE re-compares against `last_q`, so the newest value is always converted eventually.
- `bcd_o` never shows a partial result.
- `busy_o` = 1 while in SHIFT or DONE.
- **Scan prescaler:** counts 0..SCAN_DIV-1. On wrap, the digit index advances 0→1→2→3→0.
- **Digit content:**
  - Digit 0: ones, always shown.
  - Digit 1: tens; blanked if hundreds=0 and tens=0.
  - Digit 2: hundreds; blanked if hundreds=0.
  - Digit 3: `state_i` as 0..3, with dp lit.
  - dp is off on digits 0..2.
- **Blanked digit:** all segments off and its anode inactive.
- **Segment patterns (active-high form, g..a):** 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F. Outputs are inverted when ACTIVE_LOW=1.
- **Reset values:**
  - `an_o`, `seg_o`, `dp_o` all inactive; with ACTIVE_LOW=1 that is `an_o`=4'hF, `seg_o`=7'h7F, `dp_o`=1.
  - `bcd_o`=12'h000, `busy_o`=0.
  - `last_q`=0, digit index=0, prescaler=0, FSM in IDLE.
- **Reset mid-conversion:** the conversion is aborted, all state is cleared as above, and no `bcd_o` load occurs.

## Timing
- Change captured at edge k → shifts at edges k+1..k+8 → `bcd_o` loaded at edge k+9.
- `busy_o` is high after edges k..k+8, i.e. 9 cycles.
- `seg_o`, `dp_o`, `an_o` are registered: they reflect the digit index and the current `bcd_o`/`state_i` one cycle after the index changes.
- The first cycle after reset release shows digit 0.
- A new `bcd_o` appears on the display at the next registered output update.
- `state_i` is sampled combinationally into the output register, so no extra latency applies.
- Exactly one anode is active at any time, or none when the digit is blanked.

## Structure
- Package `seg7_pkg` holds:
  - the segment pattern constants for 0..9 and the blank pattern;
  - the converter FSM state localparams (2-bit);
  - the digit index width (2).
- Sub-module `bin2bcd_seq`: the IDLE/SHIFT/DONE converter.
  - Ports: `clc_i`, `rst_i`, `bin_i[7:0]`, `bcd_o[11:0]`, `busy_o`.
- The top level contains the prescaler, digit index, blanking logic, pattern decode and output registers.

## Test plan
- **Reset:** hold `rst_i` for 2 cycles (ACTIVE_LOW=1) → `an_o`=F, `seg_o`=7F, `dp_o`=1, `bcd_o`=000, `busy_o`=0. One cycle after release → `an_o`=E, `seg_o`=40 (digit "0").
- **Full-scale value:** `dind_i`=255, SCAN_DIV=4 → `busy_o` high for 9 cycles and `bcd_o`=12'h255 on the 10th edge. Scan then shows digit0 `seg_o`=12 (5), digit1=12 (5), digit2=24 (2), digit3 per `state_i`.
- **Leading-zero blanking:** `dind_i`=7 → digits 1 and 2 have an inactive anode and `seg_o`=7F; digit 0 shows `seg_o`=78. `dind_i`=40 → digit 1 shows 4 and digit 2 is blanked.
- **Change during conversion:** `dind_i`=100, then change to 42 three cycles later → `bcd_o` goes to 100, then 042 exactly 10 cycles after the first load. No other value appears.
- **State digit:** `state_i`=2 → during digit 3, `an_o`=7, `seg_o`=24, `dp_o`=0. `dp_o`=1 on all other digits.
- **Reset mid-conversion:** assert `rst_i` at iter=4 → on the next cycle `busy_o`=0 and `bcd_o`=000. After release with `dind_i` unchanged (nonzero), the value converts again.
